pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer.sv | 138 +++++++++++++
 tb/tb_pixel_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - serial pixel deserializer, clip/alpha filter and framebuffer write FIFO
module pixel_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int FRAC   = 6,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic        px,
  input  logic        py,
  input  logic        c,
  input  logic        rast_done,
  output logic        mem_req,
  output logic [16:0] mem_addr,
  output logic [15:0] mem_data,
  input  logic        mem_ack,
  output logic        tri_done,
  output logic [16:0] wr_cnt,
  output logic        overflow,
  output logic        proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [16:0] W_S = 17'(WIDTH);
  localparam logic signed [16:0] H_S = 17'(HEIGHT);
  localparam logic [16:0] W_U = 17'(WIDTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [15:0] sx, sy, sc;
  logic [15:0] wx, wy, wc;
  logic last_bit, proto_hit;
  logic signed [16:0] xs, ys;
  logic accept, push, push_ok, pop, empty, full, pending;
  logic [16:0] addr_n;
  logic [16:0] fa [DEPTH];
  logic [15:0] fd [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;

  // Word as it will look once the bit on the lines this cycle is captured.
  assign wx = {sx[14:0], px};
  assign wy = {sy[14:0], py};
  assign wc = {sc[14:0], c};

  assign xs = $signed({wx[15], wx}) >>> FRAC;
  assign ys = $signed({wy[15], wy}) >>> FRAC;
  assign accept = !xs[16] && !ys[16] && (xs < W_S) && (ys < H_S) && wc[0];
  assign addr_n = $unsigned(ys) * W_U + $unsigned(xs);

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign pop     = mem_req && mem_ack;
  assign push    = last_bit && accept;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok = push && (!full || pop);

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    last_bit  = 1'b0;
    proto_hit = 1'b0;
    tri_done  = 1'b0;
    mem_req   = !empty;
    mem_addr  = empty ? '0 : fa[rp];
    mem_data  = empty ? '0 : fd[rp];
    case (state)
      IDLE: begin
        tri_done = pending && empty;
        if (valid) begin
          state_n   = SHIFT;
          bit_cnt_n = '0;
        end
      end
      SHIFT: begin
        proto_hit = valid;
        bit_cnt_n = bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) begin
          last_bit = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sx      <= '0;
      sy      <= '0;
      sc      <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      if (state == SHIFT) begin
        sx <= wx;
        sy <= wy;
        sc <= wc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fa[wp] <= addr_n;
      fd[wp] <= wc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      wr_cnt    <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (push_ok && !pop) cnt <= cnt + (AW+1)'(1);
      else if (pop && !push_ok) cnt <= cnt - (AW+1)'(1);
      if (pop && (wr_cnt != '1)) wr_cnt <= wr_cnt + 17'd1;
      if (push && full && !pop) overflow <= 1'b1;
      if (proto_hit) proto_err <= 1'b1;
      pending <= (pending && !tri_done) || rast_done;
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - scoreboard bench for pixel_writer with directed pixel vectors
module tb_pixel_writer;
  logic        clk = 1'b0;
  logic        rst_n, valid, px, py, c, rast_done, mem_ack;
  logic        mem_req, tri_done, overflow, proto_err;
  logic [16:0] mem_addr, wr_cnt;
  logic [15:0] mem_data;

  int n_cmp = 0;
  int n_fail = 0;
  int tri_cnt = 0;
  int base;
  logic [32:0] sb_q[$];

  pixel_writer dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .px(px), .py(py), .c(c),
    .rast_done(rast_done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .tri_done(tri_done),
    .wr_cnt(wr_cnt), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted write is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (tri_done) tri_cnt++;
    if (rst_n && mem_req && mem_ack) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", mem_addr, mem_data);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e[32:16]));
        chk("write_data", 32'(mem_data), 32'(e[15:0]));
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] col,
                      input bit glitch, input bit with_rast, input bit abort);
    valid = 1'b1;
    rast_done = with_rast;
    @(posedge clk); #1;
    valid = 1'b0;
    rast_done = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (abort && i == 7) begin
        rst_n = 1'b0;
        px = 1'b0; py = 1'b0; c = 1'b0;
        return;
      end
      px = x[i]; py = y[i]; c = col[i];
      valid = glitch && (i == 8);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    px = 1'b0; py = 1'b0; c = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!mem_req) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk({name, "_drain_timeout"}, 32'(mem_req), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic expect_px(input logic [16:0] a, input logic [15:0] d);
    sb_q.push_back({a, d});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; px = 1'b0; py = 1'b0; c = 1'b0;
    rast_done = 1'b0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_data", 32'(mem_data), 0);
    chk("rst_tri_done", 32'(tri_done), 0);
    chk("rst_wr_cnt", 32'(wr_cnt), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    rst_n = 1'b1;

    // Single pixel at (10,5), ack tied high
    mem_ack = 1'b1;
    expect_px(17'd1610, 16'hF801);
    send(16'h0280, 16'h0140, 16'hF801, 0, 0, 0);
    @(negedge clk);
    chk("single_req", 32'(mem_req), 1);
    chk("single_addr", 32'(mem_addr), 1610);
    chk("single_data", 32'(mem_data), 32'hF801);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    chk("single_wr_cnt", 32'(wr_cnt), 1);

    // Rejects: x=-1, x=320, alpha=0
    send(16'hFFC0, 16'h0140, 16'hF801, 0, 0, 0);
    @(negedge clk); chk("rej_neg_x_req", 32'(mem_req), 0);
    @(posedge clk); #1;
    send(16'h5000, 16'h0140, 16'hF801, 0, 0, 0);
    @(negedge clk); chk("rej_wide_x_req", 32'(mem_req), 0);
    @(posedge clk); #1;
    send(16'h0280, 16'h0140, 16'hF800, 0, 0, 0);
    @(negedge clk); chk("rej_alpha_req", 32'(mem_req), 0);
    @(posedge clk); #1;
    chk("rej_wr_cnt", 32'(wr_cnt), 1);
    chk("rej_overflow", 32'(overflow), 0);
    chk("rej_proto_err", 32'(proto_err), 0);

    // Overflow: ack held low, six pixels at (1..6, 2)
    mem_ack = 1'b0;
    expect_px(17'd641, 16'h0001);
    expect_px(17'd642, 16'h0003);
    expect_px(17'd643, 16'h0005);
    expect_px(17'd644, 16'h0007);
    send(16'h0040, 16'h0080, 16'h0001, 0, 0, 0);
    send(16'h0080, 16'h0080, 16'h0003, 0, 0, 0);
    send(16'h00C0, 16'h0080, 16'h0005, 0, 0, 0);
    send(16'h0100, 16'h0080, 16'h0007, 0, 0, 0);
    chk("ovf_after_four", 32'(overflow), 0);
    send(16'h0140, 16'h0080, 16'h0009, 0, 0, 0);
    chk("ovf_after_five", 32'(overflow), 1);
    send(16'h0180, 16'h0080, 16'h000B, 0, 0, 0);
    mem_ack = 1'b1;
    wait_empty("ovf");
    chk("ovf_wr_cnt", 32'(wr_cnt), 5);

    // Stray VALID at T+8, pixel at bottom-right corner with fractional bits
    expect_px(17'd76799, 16'h07C1);
    send(16'h4FFF, 16'h3BFF, 16'h07C1, 1, 0, 0);
    chk("proto_err_set", 32'(proto_err), 1);
    wait_empty("proto");
    chk("proto_wr_cnt", 32'(wr_cnt), 6);

    // VALID and RAST_DONE together: TRI_DONE waits for the (discarded) pixel
    base = tri_cnt;
    send(16'h0040, 16'h0040, 16'hF800, 0, 1, 0);
    chk("merge_no_early_tri", 32'(tri_cnt), 32'(base));
    @(negedge clk); chk("merge_tri_pulse", 32'(tri_done), 1);
    @(negedge clk); chk("merge_tri_low", 32'(tri_done), 0);
    @(posedge clk); #1;

    // Three pixels, RAST_DONE, acks each delayed five cycles
    mem_ack = 1'b0;
    expect_px(17'd0, 16'h0011);
    expect_px(17'd323, 16'h1235);
    expect_px(17'd32100, 16'hABCD);
    send(16'h0000, 16'h0000, 16'h0011, 0, 0, 0);
    send(16'h00C0, 16'h0040, 16'h1235, 0, 0, 0);
    send(16'h1900, 16'h1900, 16'hABCD, 0, 0, 0);
    rast_done = 1'b1;
    @(posedge clk); #1;
    rast_done = 1'b0;
    base = tri_cnt;
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(posedge clk);
      #1 mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    chk("tri_not_before_pop", 32'(tri_cnt), 32'(base));
    @(negedge clk); chk("tri_after_third_pop", 32'(tri_done), 1);
    repeat (3) @(negedge clk);
    chk("tri_once", 32'(tri_cnt), 32'(base + 1));
    chk("tri_wr_cnt", 32'(wr_cnt), 9);
    @(posedge clk); #1;

    // Reset mid-shift with two queued entries
    send(16'h0040, 16'h0000, 16'hFFFF, 0, 0, 0);
    send(16'h0080, 16'h0000, 16'hFFFF, 0, 0, 0);
    send(16'h00C0, 16'h0000, 16'hFFFF, 0, 0, 1);
    #1;
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_data", 32'(mem_data), 0);
    chk("mid_rst_wr_cnt", 32'(wr_cnt), 0);
    chk("mid_rst_proto", 32'(proto_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_writes", 32'(wr_cnt), 0);
    expect_px(17'd1610, 16'h1111);
    send(16'h0280, 16'h0140, 16'h1111, 0, 0, 0);
    wait_empty("post_rst");
    chk("post_rst_wr_cnt", 32'(wr_cnt), 1);
    chk("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
